pktlen_filter: RTL and testbench
================================

Name: pktlen_filter

Overview:
- Successor to the short-packet dropper in the 10Gb switch AXIN packet path.
- Enforces both a minimum and a maximum packet length: runt and giant frames are dropped cleanly.
  - A packet with beats already forwarded is terminated with M_ABORT.
  - A packet with nothing forwarded yet is swallowed silently.
- Keeps saturating good/runt/giant packet counters for the switch's stats registers.
- Sits between the RX MAC/CRC stage and the router FIFO.

Parameters:
- DW, 32, bits per beat; power of 2, >=16.
- MINBYTES, 64, smallest legal packet in bytes; 0 disables the runt check.
- MAXBYTES, 1518, largest legal packet in bytes; 0 disables the giant check; must be >= MINBYTES when nonzero.
- CNTW, 32, width of each statistics counter.
- OPT_LOWPOWER, 0, zero M_DATA/M_BYTES/M_LAST whenever M_VALID is low.

Ports:
- S_CLK  in  1  clock.
- S_ARESETN  in  1  asynchronous active-low reset.
- i_clear_stats  in  1  synchronous clear of all three counters.
- S_VALID  in  1  input beat valid.
- S_READY  out  1  input beat accepted when S_VALID && S_READY.
- S_DATA  in  DW  beat data.
- S_BYTES  in  $clog2(DW/8)  valid bytes of a LAST beat; 0 means a full beat.
- S_ABORT  in  1  upstream abort of the current packet.
- S_LAST  in  1  final beat of packet.
- M_VALID  out  1  output beat valid.
- M_READY  in  1  downstream ready.
- M_DATA  out  DW  output data.
- M_BYTES  out  $clog2(DW/8)  output byte count.
- M_ABORT  out  1  output abort.
- M_LAST  out  1  output last.
- o_good_pkts  out  CNTW  packets delivered whole.
- o_runt_pkts  out  CNTW  packets dropped as short.
- o_giant_pkts  out  CNTW  packets dropped as long.

Behaviour:
- Reset:
  - S_ARESETN low immediately clears M_VALID, M_ABORT, all counters, the byte count, the out_mid flag and the state (IDLE).
  - With OPT_LOWPOWER, reset also zeroes M_DATA/M_BYTES/M_LAST.
  - A packet in flight at reset is forgotten; no M_ABORT is issued for it.
- Handshake:
  - S_READY = !M_VALID || M_READY.
  - Single registered output stage; latency is 1 cycle for forwarded beats.
  - Full throughput is maintained under continuous M_READY.
- Beat size: beat_bytes = (S_BYTES==0) ? DW/8 : S_BYTES.
- Byte count:
  - len counts bytes of accepted beats of the current packet.
  - Width is $clog2(max(MINBYTES,MAXBYTES)+DW/8+1)+1; it saturates at all-ones.
  - tot = len + beat_bytes is computed for every accepted beat.
- out_mid is set when a beat of the current packet is loaded into M. It clears on an accepted LAST, or when M_ABORT issues.
- FSM, evaluated on an accepted beat or on S_ABORT:
  - IDLE/PASS with S_ABORT: no beat is forwarded. If out_mid, M_ABORT=1 and M_VALID is cleared. Go to IDLE. No counter moves.
  - PASS, beat with MAXBYTES!=0 and tot>MAXBYTES:
    - M_ABORT if out_mid, else silent drop; pending M beat discarded.
    - o_giant_pkts++.
    - Go to DROP if !S_LAST, else IDLE.
  - PASS, LAST with tot<MINBYTES:
    - Beat not forwarded; M_ABORT if out_mid, else silent drop.
    - o_runt_pkts++.
    - Go to IDLE.
  - PASS, LAST otherwise: forward the beat with M_LAST=1; o_good_pkts++; go to IDLE.
  - PASS, non-LAST otherwise: forward the beat.
  - IDLE acts as PASS with len=0; it moves to PASS on a non-LAST forwarded beat.
  - DROP: beats are accepted (S_READY=1 once M drains) and discarded. LAST or S_ABORT returns to IDLE. No abort, no count.
- M_ABORT:
  - Asserted for exactly one cycle, with M_VALID low in that same cycle.
  - A beat of the next packet may be accepted in the abort cycle.
  - It appears on M in the next cycle with M_ABORT=0.
- Counters saturate at 2^CNTW-1.
  - i_clear_stats wins over a same-cycle increment.
- Simultaneous S_ABORT with a valid beat: the abort takes precedence and the beat is discarded.

Test Plan:
Configuration for all scenarios: DW=32, MINBYTES=64, MAXBYTES=128, M_READY=1 unless stated.
- 16 full beats, LAST BYTES=0 (64 B):
  - 16 M beats, M_LAST on the 16th, M_ABORT never.
  - o_good_pkts=1.
- 16 beats, LAST BYTES=3 (63 B):
  - 15 M beats; no 16th beat; one-cycle M_ABORT one cycle after LAST is accepted.
  - o_runt_pkts=1.
- Single beat, LAST BYTES=2:
  - M_VALID never rises, M_ABORT never rises.
  - o_runt_pkts=1.
- 40-beat packet:
  - Beats 1-32 forwarded; beat 33 (tot=132) triggers M_ABORT.
  - Beats 33-40 swallowed with S_READY=1.
  - o_giant_pkts=1.
  - The next 16-beat packet passes intact.
- S_ABORT after 5 accepted beats: exactly one M_ABORT pulse. S_ABORT in IDLE: none. Counters unchanged in both cases.
- Random M_READY stalls on good packets:
  - M beats stay stable while stalled; output matches input.
- Async S_ARESETN mid-packet: all outputs go to 0 without a clock edge.
- CNTW=2 with 5 runts: o_runt_pkts=3. i_clear_stats then gives 0.

Source files
------------

// File: rtl/pktlen_filter.sv
// pktlen_filter: drops runt and giant packets on an AXIN beat stream.
// A partially forwarded bad packet ends in a one-cycle M_ABORT; otherwise
// it is swallowed silently. Saturating good/runt/giant counters on o_*.
// Ports: S_CLK, S_ARESETN (async active-low), i_clear_stats (sync clear),
//   S_* input stream (VALID/READY/DATA/BYTES/ABORT/LAST),
//   M_* registered output stream, o_good/runt/giant_pkts statistics.
module pktlen_filter #(
   parameter int unsigned DW           = 32,
   parameter int unsigned MINBYTES     = 64,
   parameter int unsigned MAXBYTES     = 1518,
   parameter int unsigned CNTW         = 32,
   parameter bit          OPT_LOWPOWER = 1'b0
) (
   input  logic                    S_CLK,
   input  logic                    S_ARESETN,
   input  logic                    i_clear_stats,
   input  logic                    S_VALID,
   output logic                    S_READY,
   input  logic [DW-1:0]           S_DATA,
   input  logic [$clog2(DW/8)-1:0] S_BYTES,
   input  logic                    S_ABORT,
   input  logic                    S_LAST,
   output logic                    M_VALID,
   input  logic                    M_READY,
   output logic [DW-1:0]           M_DATA,
   output logic [$clog2(DW/8)-1:0] M_BYTES,
   output logic                    M_ABORT,
   output logic                    M_LAST,
   output logic [CNTW-1:0]         o_good_pkts,
   output logic [CNTW-1:0]         o_runt_pkts,
   output logic [CNTW-1:0]         o_giant_pkts
);

   localparam int unsigned BW  = $clog2(DW/8);
   localparam int unsigned BPB = DW/8;
   localparam int unsigned LIM =
      (MINBYTES > MAXBYTES) ? MINBYTES : MAXBYTES;
   localparam int unsigned LW  = $clog2(LIM + BPB + 1) + 1;

   typedef enum logic [1:0] {
      IDLE,
      PASS,
      DROP
   } state_t;

   state_t          state_q, state_d;
   logic [LW-1:0]   len_q, len_d;
   logic            out_mid_q, out_mid_d;
   logic            m_valid_q, m_valid_d;
   logic            m_abort_q, m_abort_d;
   logic [DW-1:0]   m_data_q, m_data_d;
   logic [BW-1:0]   m_bytes_q, m_bytes_d;
   logic            m_last_q, m_last_d;
   logic [CNTW-1:0] good_q, good_d;
   logic [CNTW-1:0] runt_q, runt_d;
   logic [CNTW-1:0] giant_q, giant_d;

   logic            accept;
   logic [LW-1:0]   beat_bytes;
   logic [LW:0]     tot_w;
   logic [LW-1:0]   tot;
   logic            is_giant;
   logic            is_runt;
   logic            inc_good, inc_runt, inc_giant;

   function automatic logic [CNTW-1:0] sat_inc(
      input logic [CNTW-1:0] v,
      input logic            en
   );
      return (en && (v != '1)) ? v + CNTW'(1) : v;
   endfunction

   assign S_READY    = !m_valid_q || M_READY;
   assign accept     = S_VALID && S_READY;
   assign beat_bytes = (S_BYTES == '0) ? LW'(BPB)
                                       : LW'(S_BYTES);
   assign tot_w      = {1'b0, len_q} + {1'b0, beat_bytes};
   // running length sticks at all-ones rather than wrapping
   assign tot        = tot_w[LW] ? '1 : tot_w[LW-1:0];
   assign is_giant   = (MAXBYTES != 0) && (tot > LW'(MAXBYTES));
   assign is_runt    = S_LAST && (tot < LW'(MINBYTES));

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      out_mid_d = out_mid_q;
      m_valid_d = m_valid_q && !M_READY;
      m_abort_d = 1'b0;
      m_data_d  = m_data_q;
      m_bytes_d = m_bytes_q;
      m_last_d  = m_last_q;
      inc_good  = 1'b0;
      inc_runt  = 1'b0;
      inc_giant = 1'b0;

      // abort beats any same-cycle beat, which is discarded
      if (S_ABORT) begin
         if (out_mid_q) begin
            m_abort_d = 1'b1;
            m_valid_d = 1'b0;
         end
         out_mid_d = 1'b0;
         len_d     = '0;
         state_d   = IDLE;
      end else if (accept) begin
         unique case (state_q)
            DROP: begin
               len_d = '0;
               if (S_LAST) state_d = IDLE;
            end
            default: begin
               if (is_giant) begin
                  if (out_mid_q) begin
                     m_abort_d = 1'b1;
                     m_valid_d = 1'b0;
                  end
                  out_mid_d = 1'b0;
                  len_d     = '0;
                  inc_giant = 1'b1;
                  state_d   = S_LAST ? IDLE : DROP;
               end else if (is_runt) begin
                  if (out_mid_q) begin
                     m_abort_d = 1'b1;
                     m_valid_d = 1'b0;
                  end
                  out_mid_d = 1'b0;
                  len_d     = '0;
                  inc_runt  = 1'b1;
                  state_d   = IDLE;
               end else begin
                  m_valid_d = 1'b1;
                  m_data_d  = S_DATA;
                  m_bytes_d = S_BYTES;
                  m_last_d  = S_LAST;
                  if (S_LAST) begin
                     out_mid_d = 1'b0;
                     len_d     = '0;
                     inc_good  = 1'b1;
                     state_d   = IDLE;
                  end else begin
                     out_mid_d = 1'b1;
                     len_d     = tot;
                     state_d   = PASS;
                  end
               end
            end
         endcase
      end

      if (OPT_LOWPOWER && !m_valid_d) begin
         m_data_d  = '0;
         m_bytes_d = '0;
         m_last_d  = 1'b0;
      end

      good_d  = i_clear_stats ? '0 : sat_inc(good_q, inc_good);
      runt_d  = i_clear_stats ? '0 : sat_inc(runt_q, inc_runt);
      giant_d = i_clear_stats ? '0 : sat_inc(giant_q, inc_giant);
   end

   always_ff @(posedge S_CLK or negedge S_ARESETN) begin
      if (!S_ARESETN) begin
         state_q   <= IDLE;
         len_q     <= '0;
         out_mid_q <= 1'b0;
         m_valid_q <= 1'b0;
         m_abort_q <= 1'b0;
         m_data_q  <= '0;
         m_bytes_q <= '0;
         m_last_q  <= 1'b0;
         good_q    <= '0;
         runt_q    <= '0;
         giant_q   <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         out_mid_q <= out_mid_d;
         m_valid_q <= m_valid_d;
         m_abort_q <= m_abort_d;
         m_data_q  <= m_data_d;
         m_bytes_q <= m_bytes_d;
         m_last_q  <= m_last_d;
         good_q    <= good_d;
         runt_q    <= runt_d;
         giant_q   <= giant_d;
      end
   end

   assign M_VALID      = m_valid_q;
   assign M_ABORT      = m_abort_q;
   assign M_DATA       = m_data_q;
   assign M_BYTES      = m_bytes_q;
   assign M_LAST       = m_last_q;
   assign o_good_pkts  = good_q;
   assign o_runt_pkts  = runt_q;
   assign o_giant_pkts = giant_q;

endmodule

// File: tb/tb_pktlen_filter.sv
// Bench for pktlen_filter: random packets against a packet-level model.
// A CNTW=2 copy shares the stimulus to exercise counter saturation.
module tb_pktlen_filter;

   localparam int MINB = 64;
   localparam int MAXB = 128;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr;
   logic        s_valid, s_ready, s_abort, s_last;
   logic [31:0] s_data;
   logic [1:0]  s_bytes;
   logic        m_valid, m_ready, m_abort, m_last;
   logic [31:0] m_data;
   logic [1:0]  m_bytes;
   logic [31:0] good, runt, giant;

   logic        s_ready2, m_valid2, m_abort2, m_last2;
   logic [31:0] m_data2;
   logic [1:0]  m_bytes2;
   logic [1:0]  good2, runt2, giant2;

   always #5 clk = ~clk;

   pktlen_filter #(
      .DW(32), .MINBYTES(MINB), .MAXBYTES(MAXB),
      .CNTW(32), .OPT_LOWPOWER(1'b0)
   ) dut (
      .S_CLK(clk), .S_ARESETN(rst_n), .i_clear_stats(clr),
      .S_VALID(s_valid), .S_READY(s_ready), .S_DATA(s_data),
      .S_BYTES(s_bytes), .S_ABORT(s_abort), .S_LAST(s_last),
      .M_VALID(m_valid), .M_READY(m_ready), .M_DATA(m_data),
      .M_BYTES(m_bytes), .M_ABORT(m_abort), .M_LAST(m_last),
      .o_good_pkts(good), .o_runt_pkts(runt),
      .o_giant_pkts(giant)
   );

   pktlen_filter #(
      .DW(32), .MINBYTES(MINB), .MAXBYTES(MAXB),
      .CNTW(2), .OPT_LOWPOWER(1'b1)
   ) dut_small (
      .S_CLK(clk), .S_ARESETN(rst_n), .i_clear_stats(clr),
      .S_VALID(s_valid), .S_READY(s_ready2), .S_DATA(s_data),
      .S_BYTES(s_bytes), .S_ABORT(s_abort), .S_LAST(s_last),
      .M_VALID(m_valid2), .M_READY(m_ready), .M_DATA(m_data2),
      .M_BYTES(m_bytes2), .M_ABORT(m_abort2), .M_LAST(m_last2),
      .o_good_pkts(good2), .o_runt_pkts(runt2),
      .o_giant_pkts(giant2)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // expected output events: {abort, last, bytes, data}
   logic [35:0] exp_q[$];
   localparam logic [35:0] ABORT_EV = {1'b1, 35'd0};

   int   m_good, m_runt, m_giant;
   logic rdy_rand   = 1'b0;
   logic mon_en     = 1'b1;
   logic stall_prev = 1'b0;
   logic [34:0] held;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int sat3(input int x);
      return (x > 3) ? 3 : x;
   endfunction

   task automatic pop_cmp(input logic [35:0] ev);
      if (exp_q.size() == 0) chk("extra_out", ev, 36'hF_FFFF_FFFF);
      else chk("out_event", ev, exp_q.pop_front());
   endtask

   // settle, observe the cycle, cross one edge, end on a negedge
   task automatic step(output logic acc);
      #1;
      acc = s_valid && s_ready;
      if (mon_en) begin
         if (stall_prev)
            chk("stall_hold", {m_valid, m_last, m_bytes, m_data},
                {1'b1, held});
         if (m_abort) begin
            chk("abort_vld_low", m_valid, 0);
            pop_cmp(ABORT_EV);
         end
         if (m_valid && m_ready)
            pop_cmp({1'b0, m_last, m_bytes, m_data});
         stall_prev = m_valid && !m_ready;
         held       = {m_last, m_bytes, m_data};
      end
      @(posedge clk);
      @(negedge clk);
      m_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
   endtask

   task automatic idle(input int n);
      logic acc;
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (n) step(acc);
   endtask

   task automatic drive_beat(input logic [31:0] d,
                             input logic [1:0]  b,
                             input logic        l);
      logic acc;
      int   t;
      s_valid = 1'b1;
      s_data  = d;
      s_bytes = b;
      s_last  = l;
      t = 0;
      do begin
         step(acc);
         t++;
      end while (!acc && t < 200);
      if (!acc) chk("accept_timeout", acc, 1);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic push_beats(input logic [31:0] d[],
                             input int n, input int lastb,
                             input int cnt);
      for (int i = 0; i < cnt; i++) begin
         if (i == n - 1)
            exp_q.push_back({1'b0, 1'b1, 2'(lastb), d[i]});
         else
            exp_q.push_back({1'b0, 1'b0, 2'd0, d[i]});
      end
   endtask

   // n beats, last beat carries lastb bytes (0 = 4);
   // ab >= 0 aborts after ab accepted beats
   task automatic send_pkt(input int n, input int lastb,
                           input int ab);
      logic [31:0] d[];
      int   lim, cum, g, bb;
      logic acc;
      d = new[n];
      foreach (d[i]) d[i] = $urandom;
      lim = (ab >= 0) ? ab : n;
      cum = 0;
      g   = -1;
      for (int i = 0; i < lim; i++) begin
         bb  = (i == n - 1 && lastb != 0) ? lastb : 4;
         cum += bb;
         if (cum > MAXB) begin
            g = i;
            break;
         end
      end
      if (g >= 0) begin
         push_beats(d, n, lastb, g);
         if (g > 0) exp_q.push_back(ABORT_EV);
         m_giant++;
      end else if (ab >= 0) begin
         push_beats(d, n, lastb, ab);
         if (ab > 0) exp_q.push_back(ABORT_EV);
      end else if (cum < MINB) begin
         push_beats(d, n, lastb, n - 1);
         if (n > 1) exp_q.push_back(ABORT_EV);
         m_runt++;
      end else begin
         push_beats(d, n, lastb, n);
         m_good++;
      end
      for (int i = 0; i < lim; i++)
         drive_beat(d[i], (i == n - 1) ? 2'(lastb) : 2'd0,
                    i == n - 1);
      if (ab >= 0) begin
         s_abort = 1'b1;
         s_valid = 1'($urandom_range(0, 1));
         s_data  = $urandom;
         s_last  = 1'($urandom_range(0, 1));
         m_ready = 1'b1;
         step(acc);
         s_abort = 1'b0;
         s_valid = 1'b0;
         s_last  = 1'b0;
      end
   endtask

   task automatic check_cnt();
      chk("good",    good,    m_good);
      chk("runt",    runt,    m_runt);
      chk("giant",   giant,   m_giant);
      chk("good_s",  good2,   sat3(m_good));
      chk("runt_s",  runt2,   sat3(m_runt));
      chk("giant_s", giant2,  sat3(m_giant));
      chk("drained", exp_q.size(), 0);
   endtask

   task automatic clear_stats();
      logic acc;
      clr = 1'b1;
      step(acc);
      clr     = 1'b0;
      m_good  = 0;
      m_runt  = 0;
      m_giant = 0;
   endtask

   initial begin
      int n, lb, ab;
      rst_n   = 1'b0;
      clr     = 1'b0;
      s_valid = 1'b0;
      s_abort = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
      s_bytes = '0;
      m_ready = 1'b1;
      m_good  = 0;
      m_runt  = 0;
      m_giant = 0;
      repeat (2) @(negedge clk);
      chk("rst_mvalid", m_valid, 0);
      chk("rst_mabort", m_abort, 0);
      chk("rst_sready", s_ready, 1);
      chk("rst_cnt", {good, runt, giant}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      send_pkt(16, 0, -1);
      idle(3);
      check_cnt();
      send_pkt(16, 3, -1);
      idle(3);
      check_cnt();
      send_pkt(1, 2, -1);
      idle(3);
      check_cnt();
      send_pkt(40, 0, -1);
      send_pkt(16, 0, -1);
      idle(3);
      check_cnt();
      send_pkt(10, 0, 5);
      send_pkt(4, 0, 0);
      idle(3);
      check_cnt();

      rdy_rand = 1'b1;
      repeat (30) begin
         n  = $urandom_range(1, 40);
         lb = $urandom_range(0, 3);
         ab = ($urandom_range(0, 4) == 0) ?
              int'($urandom_range(0, n - 1)) : -1;
         send_pkt(n, lb, ab);
      end
      idle(20);
      check_cnt();
      rdy_rand = 1'b0;
      idle(2);

      mon_en = 1'b0;
      for (int i = 0; i < 6; i++)
         drive_beat($urandom, 2'd0, 1'b0);
      chk("pre_rst_mvalid", m_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_mvalid", m_valid, 0);
      chk("arst_mabort", m_abort, 0);
      chk("arst_mdata", {m_last, m_bytes, m_data}, 0);
      chk("arst_cnt", {good, runt, giant}, 0);
      exp_q.delete();
      m_good     = 0;
      m_runt     = 0;
      m_giant    = 0;
      stall_prev = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);
      send_pkt(16, 0, -1);
      idle(3);
      check_cnt();

      clear_stats();
      repeat (5) send_pkt(1, 2, -1);
      idle(3);
      check_cnt();
      clear_stats();
      idle(2);
      check_cnt();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
